// File: rtl/wasca_abus_pkg.sv
// Shared types and helpers for the A-bus to on-chip RAM bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wasca_abus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Data returned for reads that fall outside the RAM.
    localparam logic [15:0] OOR_READ_DATA = 16'hFFFF;

    // Big-endian lane steering: half 0 occupies bits 31:16 of the RAM word.
    function automatic logic [3:0] lane_be(input logic half, input logic [1:0] be);
        return half ? {2'b00, be} : {be, 2'b00};
    endfunction

    // Pick the halfword addressed by 'half' out of a 32-bit word.
    function automatic logic [15:0] pick_half(input logic half, input logic [31:0] word);
        return half ? word[15:0] : word[31:16];
    endfunction

endpackage

// File: rtl/wasca_abus_rdcache.sv
// One-entry read cache (tag + 32-bit word + valid) for the A-bus RAM bridge.
// Latency: hit is combinational from lookup_addr; fill/merge take effect next cycle.
// Backpressure: none; the bridge guarantees fill and write-merge never coincide.
module wasca_abus_rdcache #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [31:0]       fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [31:0]       data;

    assign hit      = valid && (tag == lookup_addr);
    assign hit_data = data;

    // Fill on every RAM read capture; merge enabled bytes of writes that hit the cached word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (wr_en && valid && (tag == wr_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    data[8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wasca_abus_ram_bridge.sv
// Bridges 16-bit Saturn A-bus halfword requests onto a 32-bit Avalon on-chip RAM.
// Latency: write busy 2 cycles; read data 3 cycles after accept (1 on cache hit or out-of-range).
// Backpressure: req_ready only in IDLE; responses and err_pulse cannot be stalled.
// Optional read cache: define WASCA_ABUS_RAM_BRIDGE_RDCACHE_EN.
module wasca_abus_ram_bridge
    import wasca_abus_pkg::*;
#(
    parameter  int ADDR_W  = 13,
    parameter  int DEPTH   = 6144,
    localparam int HADDR_W = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [HADDR_W-1:0] req_addr,
    input  logic [1:0]         req_be,
    input  logic [15:0]        req_wdata,
    output logic               rsp_valid,
    output logic [15:0]        rsp_rdata,
    output logic               err_pulse,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [3:0]         mem_byteenable,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [31:0]        mem_writedata,
    output logic               mem_clken,
    input  logic [31:0]        mem_readdata
);

    state_t state, state_nxt;

    logic              accept;
    logic [ADDR_W-1:0] req_word;
    logic              req_half;
    logic              in_range;
    logic              rd_half, rd_half_nxt;
    logic              cache_hit;
    logic [31:0]       cache_data;

    logic              req_ready_nxt;
    logic              rsp_valid_nxt;
    logic [15:0]       rsp_rdata_nxt;
    logic              err_pulse_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [3:0]        mem_byteenable_nxt;
    logic              mem_chipselect_nxt;
    logic              mem_write_nxt;
    logic [31:0]       mem_writedata_nxt;

    assign accept   = req_valid && req_ready;
    assign req_word = req_addr[HADDR_W-1:1];
    assign req_half = req_addr[0];
    assign in_range = ({1'b0, req_word} < (ADDR_W + 1)'(DEPTH));

`ifdef WASCA_ABUS_RAM_BRIDGE_RDCACHE_EN
    wasca_abus_rdcache #(
        .ADDR_W (ADDR_W)
    ) u_rdcache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (req_word),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .fill_en     (state == CAPTURE),
        .fill_addr   (mem_address),
        .fill_data   (mem_readdata),
        .wr_en       (accept && req_write && in_range),
        .wr_addr     (req_word),
        .wr_be       (lane_be(req_half, req_be)),
        .wr_data     ({req_wdata, req_wdata})
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt          = state;
        rd_half_nxt        = rd_half;
        rsp_valid_nxt      = 1'b0;
        rsp_rdata_nxt      = rsp_rdata;
        err_pulse_nxt      = 1'b0;
        mem_chipselect_nxt = 1'b0;
        mem_write_nxt      = 1'b0;
        mem_address_nxt    = mem_address;
        mem_byteenable_nxt = mem_byteenable;
        mem_writedata_nxt  = mem_writedata;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        // No RAM cycle; reads get filler data, writes vanish.
                        err_pulse_nxt = 1'b1;
                        if (!req_write) begin
                            rsp_valid_nxt = 1'b1;
                            rsp_rdata_nxt = OOR_READ_DATA;
                        end
                    end else if (!req_write && cache_hit) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = pick_half(req_half, cache_data);
                    end else begin
                        state_nxt          = ISSUE;
                        rd_half_nxt        = req_half;
                        mem_chipselect_nxt = 1'b1;
                        mem_write_nxt      = req_write;
                        mem_address_nxt    = req_word;
                        mem_byteenable_nxt = lane_be(req_half, req_be);
                        mem_writedata_nxt  = {req_wdata, req_wdata};
                    end
                end
            end
            ISSUE: begin
                // mem_write still reflects the access being issued this cycle.
                state_nxt = mem_write ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                state_nxt     = IDLE;
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = pick_half(rd_half, mem_readdata);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        req_ready_nxt = (state_nxt == IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output registers; reset drops any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready      <= 1'b1;
            rd_half        <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            err_pulse      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_clken      <= 1'b1;
        end else begin
            req_ready      <= req_ready_nxt;
            rd_half        <= rd_half_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            err_pulse      <= err_pulse_nxt;
            mem_address    <= mem_address_nxt;
            mem_byteenable <= mem_byteenable_nxt;
            mem_chipselect <= mem_chipselect_nxt;
            mem_write      <= mem_write_nxt;
            mem_writedata  <= mem_writedata_nxt;
            mem_clken      <= 1'b1;
        end
    end

endmodule
